// File: rtl/ysyx_22050078_dmem_if.sv
// Load/store port between the core LSU (master) and the data-memory
// responder (slave).
//   request : i_req_valid / o_req_ready handshake carrying wen, byte addr,
//             low-aligned store data and low-aligned byte mask
//   response: o_rsp_valid / i_rsp_ready handshake carrying low-aligned
//             load data and an out-of-range error flag
// Signal names keep the responder's point of view (i_ = into the dmem).
interface ysyx_22050078_dmem_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wen;
  logic [63:0] i_req_addr;
  logic [63:0] i_req_wdata;
  logic [7:0]  i_req_wmask;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [63:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport master (
    output i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wmask,
    output i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wmask,
    input  i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/ysyx_22050078_dmem.sv
// Data-memory responder: accepts one load/store at a time, accesses a
// doubleword RAM at accept, and answers LAT cycles later.
//   i_clk  : clock, all state changes on the rising edge
//   i_rst  : synchronous active-high reset
//   bus    : request/response channels (slave side of ysyx_22050078_dmem_if)
// Parameters: DEPTH 64-bit words (power of two, >= 2), BASE byte address of
// word 0, LAT accept-to-response latency (1..15).
module ysyx_22050078_dmem #(
  parameter int unsigned DEPTH = 4096,
  parameter logic [63:0] BASE  = 64'h8000_0000,
  parameter int unsigned LAT   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ysyx_22050078_dmem_if.slave   bus
);

  localparam int unsigned   IDXW     = $clog2(DEPTH);
  localparam int unsigned   CNTW     = 4;
  localparam logic [63:0]   SPAN     = 64'(DEPTH) << 3;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [63:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [63:0]     mem [DEPTH];

  logic [63:0]     rel_addr;
  logic            in_range;
  logic [IDXW-1:0] idx;
  logic [2:0]      off;
  logic [5:0]      sh;
  logic [63:0]     word;
  logic [7:0]      lane_mask;
  logic [63:0]     lane_data;
  logic [63:0]     bit_mask;
  logic [63:0]     wr_word;
  logic            accept;
  logic            mem_we;

  // Address decode and store lane alignment. Subtracting BASE first makes
  // addresses below BASE wrap to huge values, so one compare covers both ends.
  always_comb begin
    rel_addr  = bus.i_req_addr - BASE;
    in_range  = rel_addr < SPAN;
    idx       = rel_addr[IDXW+2:3];
    off       = bus.i_req_addr[2:0];
    sh        = {off, 3'b000};
    word      = mem[idx];
    // Shifting into 8/64-bit results drops bytes past lane 7 (truncation).
    lane_mask = bus.i_req_wmask << off;
    lane_data = bus.i_req_wdata << sh;
    bit_mask  = '0;
    for (int b = 0; b < 8; b++) begin
      bit_mask[8*b +: 8] = {8{lane_mask[b]}};
    end
    wr_word   = (word & ~bit_mask) | (lane_data & bit_mask);
    accept    = bus.i_req_valid & req_ready_q & ~i_rst;
    mem_we    = accept & bus.i_req_wen & in_range;
  end

  // Next-state and output logic; the response is computed at accept and held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rdata_d = (bus.i_req_wen || !in_range) ? 64'h0 : (word >> sh);
          err_d   = ~in_range;
          if (LAT <= 1) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.i_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // Control and response registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // RAM write, committed at store accept; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[idx] <= wr_word;
    end
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_22050078_dmem.sv
// Scoreboard bench for ysyx_22050078_dmem: a byte-addressed reference memory
// predicts every response, a monitor checks responses and their latency.
module tb_ysyx_22050078_dmem;

  localparam int unsigned DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ysyx_22050078_dmem_if bus ();

  ysyx_22050078_dmem #(.DEPTH(DEPTH), .BASE(BASE), .LAT(LAT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t      exp_q[$];
  bit [7:0]  mdl [bit [63:0]];
  int        n_chk = 0;
  int        n_err = 0;
  int        cyc   = 0;
  bit        force_en  = 1'b0;
  bit        force_val = 1'b1;
  bit        prev_v    = 1'b0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit in_rng(input bit [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * DEPTH));
  endfunction

  // Byte-level view: the response starts at the addressed byte and stops at
  // the end of its doubleword.
  function automatic logic [63:0] mdl_load(input bit [63:0] a);
    logic [63:0] r;
    int          off;
    r   = '0;
    off = int'(a[2:0]);
    for (int i = 0; i < 8; i++) begin
      if (off + i < 8) r[8*i +: 8] = mdl.exists(a + 64'(i)) ? mdl[a + 64'(i)] : 8'h00;
    end
    return r;
  endfunction

  task automatic mdl_store(input bit [63:0] a, input bit [63:0] d, input bit [7:0] m);
    int off;
    off = int'(a[2:0]);
    for (int i = 0; i < 8; i++) begin
      if (m[i] && (off + i < 8)) mdl[a + 64'(i)] = d[8*i +: 8];
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response backpressure: random unless a directed test forces it.
  always @(posedge clk) begin
    #1;
    bus.i_rsp_ready = force_en ? force_val : ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency on the rising response, data/err on each handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.o_rsp_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: o_rsp_valid 1 with no request outstanding, required 0 (cycle %0d)", cyc);
        end else begin
          check64("rsp_latency", 64'(cyc - exp_q[0].acc), 64'(LAT - 1));
        end
      end
      if (bus.o_rsp_valid && bus.i_rsp_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check64("rsp_rdata", bus.o_rsp_rdata, e.rdata);
        check64("rsp_err", {63'b0, bus.o_rsp_err}, {63'b0, e.err});
      end
      prev_v = bus.o_rsp_valid;
    end
  end

  // Issue one request; called and returns at 1 time unit after a rising edge.
  task automatic do_req(input bit wen, input bit [63:0] addr, input bit [63:0] wdata,
                        input bit [7:0] wmask, output int waited);
    exp_t e;
    bit   ok;
    bus.i_req_valid = 1'b1;
    bus.i_req_wen   = wen;
    bus.i_req_addr  = addr;
    bus.i_req_wdata = wdata;
    bus.i_req_wmask = wmask;
    waited = 0;
    ok     = 1'b0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (bus.o_req_ready && !rst) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL req_timeout: o_req_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      e.err   = !in_rng(addr);
      e.rdata = (wen || e.err) ? 64'h0 : mdl_load(addr);
      if (wen && !e.err) mdl_store(addr, wdata, wmask);
      e.acc   = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_req_wen   = 1'($urandom);
    bus.i_req_addr  = {$urandom, $urandom};
    bus.i_req_wdata = {$urandom, $urandom};
    bus.i_req_wmask = 8'($urandom);
  endtask

  task automatic req(input bit wen, input bit [63:0] addr, input bit [63:0] wdata, input bit [7:0] wmask);
    int w;
    do_req(wen, addr, wdata, wmask, w);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check64("drain_outstanding", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit [7:0] masks [5];
    bit [63:0] a;
    int        w;
    int        pick;
    masks[0] = 8'h00; masks[1] = 8'h01; masks[2] = 8'h03; masks[3] = 8'h0F; masks[4] = 8'hFF;

    bus.i_req_valid = 1'b0;
    bus.i_req_wen   = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    bus.i_req_wmask = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check64("reset_req_ready", {63'b0, bus.o_req_ready}, 64'h0);
    check64("reset_rsp_valid", {63'b0, bus.o_rsp_valid}, 64'h0);
    check64("reset_rsp_rdata", bus.o_rsp_rdata, 64'h0);
    check64("reset_rsp_err", {63'b0, bus.o_rsp_err}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check64("idle_req_ready", {63'b0, bus.o_req_ready}, 64'h1);
    check64("idle_rsp_valid", {63'b0, bus.o_rsp_valid}, 64'h0);
    @(posedge clk);
    #1;

    // Prefill the working window and the last in-range word.
    for (int i = 0; i < 16; i++) req(1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
    req(1'b1, BASE + 64'(8 * (DEPTH - 1)), {$urandom, $urandom}, 8'hFF);

    // Full doubleword store then load.
    req(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    req(1'b0, 64'h8000_0010, 64'h0, 8'h00);

    // Single byte lane.
    req(1'b1, 64'h8000_0000, 64'h0, 8'hFF);
    req(1'b1, 64'h8000_0003, 64'hAB, 8'h01);
    req(1'b0, 64'h8000_0000, 64'h0, 8'h00);
    req(1'b0, 64'h8000_0003, 64'h0, 8'h00);

    // Out of range below and just above the RAM.
    req(1'b0, 64'h0000_1000, 64'h0, 8'h00);
    req(1'b1, BASE + 64'(8 * DEPTH), 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    req(1'b0, BASE + 64'(8 * (DEPTH - 1)), 64'h0, 8'h00);

    // Store crossing the doubleword boundary is truncated.
    req(1'b1, 64'h8000_0006, 64'hDDCC_BBAA, 8'h0F);
    req(1'b0, 64'h8000_0000, 64'h0, 8'h00);
    req(1'b0, 64'h8000_0008, 64'h0, 8'h00);
    wait_idle();
    check64("trunc_word_model", mdl_load(64'h8000_0000), 64'hBBAA_0000_AB00_0000);

    // Backpressure: response held 5 cycles, then back-to-back accept.
    force_val = 1'b0;
    force_en  = 1'b1;
    req(1'b0, 64'h8000_0010, 64'h0, 8'h00);
    w = 0;
    while (!bus.o_rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check64("bp_rsp_seen", {63'b0, bus.o_rsp_valid}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check64("bp_valid_held", {63'b0, bus.o_rsp_valid}, 64'h1);
      check64("bp_rdata_held", bus.o_rsp_rdata, 64'h1122_3344_5566_7788);
      check64("bp_req_ready_low", {63'b0, bus.o_req_ready}, 64'h0);
    end
    @(posedge clk);
    #1;
    force_val = 1'b1;
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b0, 64'h8000_0003, 64'h0, 8'h00, w);
    check64("bp_back_to_back_wait", 64'(w), 64'h0);
    force_en = 1'b0;
    wait_idle();

    // Reset while the store waits: store stays, response is dropped.
    @(posedge clk);
    #1;
    req(1'b1, 64'h8000_0020, 64'h0BAD_F00D_1234_5678, 8'hFF);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check64("rst_mid_rsp_valid", {63'b0, bus.o_rsp_valid}, 64'h0);
    check64("rst_mid_rsp_rdata", bus.o_rsp_rdata, 64'h0);
    check64("rst_mid_rsp_err", {63'b0, bus.o_rsp_err}, 64'h0);
    check64("rst_mid_req_ready", {63'b0, bus.o_req_ready}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check64("rst_no_rsp", {63'b0, bus.o_rsp_valid}, 64'h0);
    end
    check64("rst_ready_back", {63'b0, bus.o_req_ready}, 64'h1);
    @(posedge clk);
    #1;
    req(1'b0, 64'h8000_0020, 64'h0, 8'h00);

    // Random mix of loads/stores, aligned and misaligned, some out of range.
    for (int n = 0; n < 300; n++) begin
      pick = int'($urandom_range(0, 19));
      if (pick == 0)      a = 64'($urandom_range(0, 32'h7FFF_FFFF));
      else if (pick == 1) a = BASE + 64'(8 * DEPTH) + 64'($urandom_range(0, 255));
      else if (pick == 2) a = BASE - 64'($urandom_range(1, 64));
      else                a = BASE + 64'($urandom_range(0, 127));
      req(1'($urandom), a, {$urandom, $urandom}, masks[$urandom_range(0, 4)]);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
